pll_reconf_seq: RTL and testbench

PLL_RECONF_SEQ -- requirements
Module: pll_reconf_seq

---
 rtl/pll_reconf_pkg.sv | 48 ++++
 rtl/pll_reconf_seq_if.sv | 39 +++
 rtl/pll_reconf_avmm.sv | 73 +++++++
 rtl/pll_reconf_seq.sv | 193 +++++++++++++++++++
 tb/tb_pll_reconf_seq.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_reconf_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
// Macro PLL_RECONF_FRAC_EN adds the fractional (K) write state.
package pll_reconf_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MODE,
    ST_WR_N,
    ST_WR_M,
    ST_WR_C0,
    ST_WR_C1,
`ifdef PLL_RECONF_FRAC_EN
    ST_WR_K,
`endif
    ST_START,
    ST_POLL,
    ST_WAIT_LOCK
  } state_e;

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_N      = 6'd3;
  localparam logic [5:0] ADDR_M      = 6'd4;
  localparam logic [5:0] ADDR_C      = 6'd5;
  localparam logic [5:0] ADDR_K      = 6'd7;

  localparam logic [31:0] MODE_POLLING = 32'd1;
  localparam logic [4:0]  C_SEL_C0     = 5'd0;
  localparam logic [4:0]  C_SEL_C1     = 5'd1;

  typedef struct packed {
    logic       odd;
    logic       bypass;
    logic [7:0] hi;
    logic [7:0] lo;
  } cnt_word_t;

  function automatic logic [31:0] nm_word(input cnt_word_t w);
    return {14'b0, w};
  endfunction

  // The C register carries the output-counter select just above the counter word.
  function automatic logic [31:0] c_word(input logic [4:0] sel, input cnt_word_t w);
    return {9'b0, sel, w};
  endfunction

endpackage

// File: rtl/pll_reconf_seq_if.sv
// Command and Avalon-MM signal bundle for pll_reconf_seq.
// Same bundle for both values of PLL_RECONF_FRAC_EN; cmd_k is simply unused without it.
interface pll_reconf_seq_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [17:0] cmd_m;
  logic [17:0] cmd_n;
  logic [17:0] cmd_c0;
  logic [17:0] cmd_c1;
  logic [31:0] cmd_k;

  logic [5:0]  mgmt_address;
  logic        mgmt_read;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;

  logic        pll_locked;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  cmd_valid, cmd_m, cmd_n, cmd_c0, cmd_c1, cmd_k,
    input  mgmt_readdata, mgmt_waitrequest, pll_locked,
    output cmd_ready, mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_m, cmd_n, cmd_c0, cmd_c1, cmd_k,
    output mgmt_readdata, mgmt_waitrequest, pll_locked,
    input  cmd_ready, mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
    input  busy, done, err
  );

endinterface

// File: rtl/pll_reconf_avmm.sv
// Single-access Avalon-MM master: launches one read or write per req and
// holds it while waitrequest is high. Not affected by PLL_RECONF_FRAC_EN.
module pll_reconf_avmm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rnw,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_read,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest
);

  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        active;

  assign active = read_q | write_q;
  assign ack    = active & ~mgmt_waitrequest;
  // Readdata is forwarded in the completing cycle so the caller can branch on it at once.
  assign rdata  = (ack && read_q) ? mgmt_readdata : rdata_q;

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    rdata_d = rdata_q;
    if (ack) begin
      addr_d  = 6'd0;
      wdata_d = 32'd0;
      read_d  = 1'b0;
      write_d = 1'b0;
      if (read_q) rdata_d = mgmt_readdata;
    end else if (req && !active) begin
      addr_d  = addr;
      wdata_d = rnw ? 32'd0 : wdata;
      read_d  = rnw;
      write_d = ~rnw;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= 6'd0;
      wdata_q <= 32'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  assign mgmt_address   = addr_q;
  assign mgmt_read      = read_q;
  assign mgmt_write     = write_q;
  assign mgmt_writedata = wdata_q;

endmodule

// File: rtl/pll_reconf_seq.sv
// PLL reconfiguration sequencer: writes mode/N/M/C0/C1[/K], starts, polls, waits for lock.
// Define PLL_RECONF_FRAC_EN to include the fractional K write.
module pll_reconf_seq
  import pll_reconf_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 65535,
  parameter int POLL_MAX     = 1023
) (
  input logic              clk,
  input logic              rst_n,
  pll_reconf_seq_if.master bus
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);

  state_e          state_q, state_d;
  cnt_word_t       m_q, m_d, n_q, n_d, c0_q, c0_d, c1_q, c1_d;
`ifdef PLL_RECONF_FRAC_EN
  logic [31:0]     k_q, k_d;
`endif
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;

  logic            acc_rnw;
  logic [5:0]      acc_addr;
  logic [31:0]     acc_wdata;
  logic            ack;
  logic [31:0]     rdata;

  // The state alone decides what the pending access is; the master latches it on req.
  always_comb begin
    acc_rnw   = 1'b0;
    acc_addr  = ADDR_MODE;
    acc_wdata = 32'd0;
    case (state_q)
      ST_MODE:  acc_wdata = MODE_POLLING;
      ST_WR_N:  begin acc_addr = ADDR_N; acc_wdata = nm_word(n_q); end
      ST_WR_M:  begin acc_addr = ADDR_M; acc_wdata = nm_word(m_q); end
      ST_WR_C0: begin acc_addr = ADDR_C; acc_wdata = c_word(C_SEL_C0, c0_q); end
      ST_WR_C1: begin acc_addr = ADDR_C; acc_wdata = c_word(C_SEL_C1, c1_q); end
`ifdef PLL_RECONF_FRAC_EN
      ST_WR_K:  begin acc_addr = ADDR_K; acc_wdata = k_q; end
`endif
      ST_START: acc_addr = ADDR_START;
      ST_POLL:  begin acc_addr = ADDR_STATUS; acc_rnw = 1'b1; end
      default:  acc_addr = ADDR_MODE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    n_d        = n_q;
    c0_d       = c0_q;
    c1_d       = c1_q;
`ifdef PLL_RECONF_FRAC_EN
    k_d        = k_q;
`endif
    poll_cnt_d = poll_cnt_q;
    lock_cnt_d = lock_cnt_q;
    req_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          m_d     = bus.cmd_m;
          n_d     = bus.cmd_n;
          c0_d    = bus.cmd_c0;
          c1_d    = bus.cmd_c1;
`ifdef PLL_RECONF_FRAC_EN
          k_d     = bus.cmd_k;
`endif
          state_d = ST_MODE;
          req_d   = 1'b1;
        end
      end
      ST_MODE:  if (ack) begin state_d = ST_WR_N;  req_d = 1'b1; end
      ST_WR_N:  if (ack) begin state_d = ST_WR_M;  req_d = 1'b1; end
      ST_WR_M:  if (ack) begin state_d = ST_WR_C0; req_d = 1'b1; end
      ST_WR_C0: if (ack) begin state_d = ST_WR_C1; req_d = 1'b1; end
`ifdef PLL_RECONF_FRAC_EN
      ST_WR_C1: if (ack) begin state_d = ST_WR_K;  req_d = 1'b1; end
      ST_WR_K:  if (ack) begin state_d = ST_START; req_d = 1'b1; end
`else
      ST_WR_C1: if (ack) begin state_d = ST_START; req_d = 1'b1; end
`endif
      ST_START: begin
        if (ack) begin
          state_d    = ST_POLL;
          req_d      = 1'b1;
          poll_cnt_d = '0;
        end
      end
      // poll_cnt holds the number of status reads already completed before this one.
      ST_POLL: begin
        if (ack) begin
          if (rdata[0]) begin
            state_d    = ST_WAIT_LOCK;
            lock_cnt_d = '0;
          end else if (poll_cnt_q >= POLL_LAST) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            req_d      = 1'b1;
          end
        end
      end
      ST_WAIT_LOCK: begin
        if (bus.pll_locked) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (lock_cnt_q >= LOCK_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      m_q        <= '0;
      n_q        <= '0;
      c0_q       <= '0;
      c1_q       <= '0;
`ifdef PLL_RECONF_FRAC_EN
      k_q        <= '0;
`endif
      poll_cnt_q <= '0;
      lock_cnt_q <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      c0_q       <= c0_d;
      c1_q       <= c1_d;
`ifdef PLL_RECONF_FRAC_EN
      k_q        <= k_d;
`endif
      poll_cnt_q <= poll_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      req_q      <= req_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  pll_reconf_avmm u_avmm (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req_q),
    .rnw              (acc_rnw),
    .addr             (acc_addr),
    .wdata            (acc_wdata),
    .ack              (ack),
    .rdata            (rdata),
    .mgmt_address     (bus.mgmt_address),
    .mgmt_read        (bus.mgmt_read),
    .mgmt_write       (bus.mgmt_write),
    .mgmt_writedata   (bus.mgmt_writedata),
    .mgmt_readdata    (bus.mgmt_readdata),
    .mgmt_waitrequest (bus.mgmt_waitrequest)
  );

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pll_reconf_seq.sv
// Self-checking bench for pll_reconf_seq: an Avalon slave/lock responder logs every
// access and a command-level model predicts the access list and outcome.
module tb_pll_reconf_seq;

  localparam int TB_POLL_MAX     = 4;
  localparam int TB_LOCK_TIMEOUT = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pll_reconf_seq_if bus ();

  pll_reconf_seq #(
    .LOCK_TIMEOUT (TB_LOCK_TIMEOUT),
    .POLL_MAX     (TB_POLL_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  int cfg_wait       = 0;
  int cfg_ok_after   = 0;
  int cfg_lock_delay = -1;

  int cyc          = 0;
  int lock_at      = -1;
  int rd_seen      = 0;
  int done_cnt     = 0;
  int err_cnt      = 0;
  int both_cnt     = 0;
  int rw_cnt       = 0;
  int unstable_cnt = 0;
  int done_cyc     = -1;
  int err_cyc      = -1;
  int last_rd_cyc  = -1;

  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic        log_rd[$];
  int          log_hold[$];

  logic [17:0] exp_m, exp_n, exp_c0, exp_c1;
  logic [31:0] exp_k;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Avalon slave, lock source and output monitor, all acting on the falling edge.
  initial begin
    bit          in_acc;
    int          hold;
    int          wleft;
    logic [5:0]  a0;
    logic [31:0] d0;
    logic        r0;
    logic [31:0] rnd;
    logic        ok;
    in_acc = 1'b0;
    hold   = 0;
    wleft  = 0;
    bus.mgmt_waitrequest = 1'b0;
    bus.mgmt_readdata    = 32'd0;
    bus.pll_locked       = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.err) begin err_cnt++; err_cyc = cyc; end
      if (bus.done && bus.err) both_cnt++;
      if (bus.mgmt_read && bus.mgmt_write) rw_cnt++;
      if (lock_at >= 0 && cyc >= lock_at) bus.pll_locked = 1'b1;
      if (bus.mgmt_read || bus.mgmt_write) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          hold   = 0;
          wleft  = cfg_wait;
          a0     = bus.mgmt_address;
          d0     = bus.mgmt_writedata;
          r0     = bus.mgmt_read;
        end else if (bus.mgmt_address !== a0 || bus.mgmt_writedata !== d0 || bus.mgmt_read !== r0) begin
          unstable_cnt++;
        end
        hold++;
        if (wleft > 0) begin
          bus.mgmt_waitrequest = 1'b1;
          wleft--;
        end else begin
          bus.mgmt_waitrequest = 1'b0;
          log_addr.push_back(a0);
          log_data.push_back(d0);
          log_rd.push_back(r0);
          log_hold.push_back(hold);
          if (r0) begin
            ok  = (cfg_ok_after >= 0) && (rd_seen >= cfg_ok_after);
            rnd = $urandom();
            bus.mgmt_readdata = {rnd[31:1], ok};
            rd_seen++;
            last_rd_cyc = cyc;
            if (ok && cfg_lock_delay >= 0) lock_at = cyc + cfg_lock_delay;
          end
          in_acc = 1'b0;
        end
      end else begin
        in_acc = 1'b0;
        bus.mgmt_waitrequest = 1'b0;
      end
    end
  end

  task automatic clearLogs();
    log_addr.delete();
    log_data.delete();
    log_rd.delete();
    log_hold.delete();
    rd_seen      = 0;
    done_cnt     = 0;
    err_cnt      = 0;
    both_cnt     = 0;
    rw_cnt       = 0;
    unstable_cnt = 0;
    done_cyc     = -1;
    err_cyc      = -1;
    last_rd_cyc  = -1;
    lock_at      = -1;
    bus.pll_locked = 1'b0;
  endtask

  task automatic sendCmd(input logic [17:0] m, input logic [17:0] n, input logic [17:0] c0,
                         input logic [17:0] c1, input logic [31:0] k);
    exp_m = m; exp_n = n; exp_c0 = c0; exp_c1 = c1; exp_k = k;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_m = m; bus.cmd_n = n; bus.cmd_c0 = c0; bus.cmd_c1 = c1; bus.cmd_k = k;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_m  = 18'($urandom());
    bus.cmd_n  = 18'($urandom());
    bus.cmd_c0 = 18'($urandom());
    bus.cmd_c1 = 18'($urandom());
    bus.cmd_k  = $urandom();
  endtask

  task automatic applyStimulus(input logic [17:0] m, input logic [17:0] n, input logic [17:0] c0,
                               input logic [17:0] c1, input logic [31:0] k, input int wait_cycles,
                               input int ok_after, input int lock_delay, input bit spurious);
    int t;
    clearLogs();
    cfg_wait       = wait_cycles;
    cfg_ok_after   = ok_after;
    cfg_lock_delay = lock_delay;
    sendCmd(m, n, c0, c1, k);
    if (spurious) begin
      repeat (6) @(negedge clk);
      chk("busy_before_spurious_cmd", bus.busy, 1'b1);
      bus.cmd_valid = 1'b1;
      bus.cmd_m  = 18'($urandom());
      bus.cmd_c1 = 18'($urandom());
      bus.cmd_k  = $urandom();
      repeat (2) @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    t = 0;
    while (done_cnt + err_cnt == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("finished_within_budget", 32'(t < 2000), 32'd1);
    repeat (20) @(negedge clk);
  endtask

  // Expected behaviour derived from the command and the responder settings alone.
  task automatic checkOutput(input string tag);
    logic [5:0]  ea[$];
    logic [31:0] ed[$];
    logic        er[$];
    bit          status_ok;
    bit          exp_done;
    int          n_rd;
    int          n_min;
    ea.push_back(6'd0); ed.push_back(32'd1);                      er.push_back(1'b0);
    ea.push_back(6'd3); ed.push_back({14'b0, exp_n});             er.push_back(1'b0);
    ea.push_back(6'd4); ed.push_back({14'b0, exp_m});             er.push_back(1'b0);
    ea.push_back(6'd5); ed.push_back({14'b0, exp_c0});            er.push_back(1'b0);
    ea.push_back(6'd5); ed.push_back({13'b0, 1'b1, exp_c1});      er.push_back(1'b0);
`ifdef PLL_RECONF_FRAC_EN
    ea.push_back(6'd7); ed.push_back(exp_k);                      er.push_back(1'b0);
`endif
    ea.push_back(6'd2); ed.push_back(32'd0);                      er.push_back(1'b0);
    status_ok = (cfg_ok_after >= 0) && (cfg_ok_after < TB_POLL_MAX);
    n_rd      = status_ok ? cfg_ok_after + 1 : TB_POLL_MAX;
    for (int i = 0; i < n_rd; i++) begin
      ea.push_back(6'd1); ed.push_back(32'd0); er.push_back(1'b1);
    end
    exp_done = status_ok && (cfg_lock_delay >= 0);

    chk($sformatf("%s_access_count", tag), log_addr.size(), ea.size());
    n_min = (log_addr.size() < ea.size()) ? log_addr.size() : ea.size();
    for (int i = 0; i < n_min; i++) begin
      chk($sformatf("%s_acc%0d_addr", tag, i), log_addr[i], ea[i]);
      chk($sformatf("%s_acc%0d_is_read", tag, i), log_rd[i], er[i]);
      if (!er[i]) chk($sformatf("%s_acc%0d_data", tag, i), log_data[i], ed[i]);
      chk($sformatf("%s_acc%0d_strobe_cycles", tag, i), log_hold[i], cfg_wait + 1);
    end
    chk($sformatf("%s_done_pulses", tag), done_cnt, exp_done ? 1 : 0);
    chk($sformatf("%s_err_pulses", tag), err_cnt, exp_done ? 0 : 1);
    if (exp_done)
      chk($sformatf("%s_done_timing", tag), done_cyc, last_rd_cyc + cfg_lock_delay + 1);
    else if (status_ok)
      chk($sformatf("%s_timeout_timing", tag), err_cyc, last_rd_cyc + TB_LOCK_TIMEOUT + 1);
    chk($sformatf("%s_done_err_overlap", tag), both_cnt, 0);
    chk($sformatf("%s_read_write_overlap", tag), rw_cnt, 0);
    chk($sformatf("%s_strobe_unstable", tag), unstable_cnt, 0);
    chk($sformatf("%s_busy_after", tag), bus.busy, 1'b0);
    chk($sformatf("%s_ready_after", tag), bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    bus.cmd_valid = 1'b0;
    bus.cmd_m  = '0;
    bus.cmd_n  = '0;
    bus.cmd_c0 = '0;
    bus.cmd_c1 = '0;
    bus.cmd_k  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_err", bus.err, 1'b0);
    chk("reset_read", bus.mgmt_read, 1'b0);
    chk("reset_write", bus.mgmt_write, 1'b0);
    chk("reset_address", bus.mgmt_address, 6'd0);
    chk("reset_writedata", bus.mgmt_writedata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready", bus.cmd_ready, 1'b1);
    chk("release_busy", bus.busy, 1'b0);

    $display("[TB] nominal command, no wait states");
    applyStimulus(18'h00404, 18'h10101, 18'h20403, 18'h00707, 32'hD3EC_5D7D, 0, 0, 10, 1'b0);
    checkOutput("nominal");

    $display("[TB] nominal command, three wait states per access");
    applyStimulus(18'h00404, 18'h10101, 18'h20403, 18'h00707, 32'hD3EC_5D7D, 3, 0, 10, 1'b0);
    checkOutput("waitstates");

    $display("[TB] status never reports done");
    applyStimulus(18'h00404, 18'h10101, 18'h20403, 18'h00707, 32'hD3EC_5D7D, 0, -1, 10, 1'b0);
    checkOutput("poll_exhausted");

    $display("[TB] lock never arrives");
    applyStimulus(18'h00404, 18'h10101, 18'h20403, 18'h00707, 32'hD3EC_5D7D, 0, 0, -1, 1'b0);
    checkOutput("lock_timeout");

    $display("[TB] reset during the M write with waitrequest held");
    clearLogs();
    cfg_wait = 50;
    sendCmd(18'h00404, 18'h10101, 18'h20403, 18'h00707, 32'hD3EC_5D7D);
    t = 0;
    while (!(bus.mgmt_write && bus.mgmt_address == 6'd4) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("reached_wr_m", 32'(t < 400), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_write", bus.mgmt_write, 1'b0);
    chk("abort_address", bus.mgmt_address, 6'd0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_ready", bus.cmd_ready, 1'b1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_err", err_cnt, 0);
    applyStimulus(18'h00404, 18'h10101, 18'h20403, 18'h00707, 32'hD3EC_5D7D, 0, 0, 10, 1'b0);
    checkOutput("after_abort");

    $display("[TB] new command pulsed while busy");
    applyStimulus(18'h00404, 18'h10101, 18'h20403, 18'h00707, 32'hD3EC_5D7D, 1, 1, 5, 1'b1);
    checkOutput("busy_cmd_ignored");

    $display("[TB] randomized commands");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(18'($urandom()), 18'($urandom()), 18'($urandom()), 18'($urandom()), $urandom(),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(1, 60)), 1'($urandom_range(0, 1)));
      checkOutput($sformatf("random%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
